// File: rtl/cpu_memory.sv
// Single-port synchronous memory on a shared bidirectional data bus.
// Define MEM_RST_CLEAR_EN to make reset also clear every array location.
module cpu_memory #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data_io
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
`ifdef MEM_RST_CLEAR_EN
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
`endif
    end else begin
      if (wr) begin
        mem[addr] <= data_io;
      end
      // A write in the same cycle wins the bus, so the read register holds.
      if (rd && !wr) begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign data_io = (rd && !wr) ? rdata_q : 'z;

endmodule

// File: tb/tb_cpu_memory.sv
// Directed self-checking bench for cpu_memory; a weak pull-up makes an
// undriven bus read as all ones.
module tb_cpu_memory;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic       rd;
  logic [4:0] addr;
  logic [7:0] drv;
  logic       drv_en;
  wire  [7:0] data_io;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [7:0] FLOAT = 8'hff;

  assign data_io = drv_en ? drv : 'z;

  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup (data_io[g]);
  end

  always #5 clk = ~clk;

  cpu_memory #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .wr     (wr),
    .rd     (rd),
    .addr   (addr),
    .data_io(data_io)
  );

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    wr = 1'b1; rd = 1'b0; addr = a; drv = d; drv_en = 1'b1;
    @(negedge clk);
    wr = 1'b0; drv_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [4:0] a, output logic [7:0] d);
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; addr = a;
    @(posedge clk);
    #1 d = data_io;
    @(negedge clk);
    rd = 1'b0;
  endtask

  logic [7:0] rv;

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; drv = '0; drv_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_val("reset_idle_float", data_io, FLOAT);
    rd = 1'b1;
    #1 check_val("reset_rdata_zero", data_io, 8'h00);
    rd = 1'b0;

    // Pattern fill and readback
    for (int i = 0; i < 32; i++) begin
      rv = 8'(i);
      do_write(rv[4:0], rv);
    end
    for (int i = 0; i < 32; i++) begin
      logic [7:0] exp;
      exp = 8'(i);
      do_read(exp[4:0], rv);
      check_val($sformatf("fill_%0d", i), rv, exp);
    end

    // Back-to-back reads with rd held
    @(negedge clk);
    rd = 1'b1; addr = 5'd0;
    @(posedge clk); #1 check_val("b2b_0", data_io, 8'h00);
    @(negedge clk); addr = 5'd1;
    #1 check_val("b2b_lat_1", data_io, 8'h00);
    @(posedge clk); #1 check_val("b2b_1", data_io, 8'h01);
    @(negedge clk); addr = 5'd2;
    @(posedge clk); #1 check_val("b2b_2", data_io, 8'h02);

    // Bus release; rdata_q now holds 8'h02
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    #1 check_val("rel_rd0_wr0", data_io, FLOAT);
    wr = 1'b1; addr = 5'd9;
    #1 check_val("rel_rd0_wr1", data_io, FLOAT);
    rd = 1'b1;
    #1 check_val("rel_rd1_wr1", data_io, FLOAT);
    wr = 1'b0; rd = 1'b0;
    @(negedge clk);
    wr = 1'b1; rd = 1'b1; addr = 5'd3; drv = 8'h5a; drv_en = 1'b1;
    #1 check_val("rel_bus_clean", data_io, 8'h5a);
    @(negedge clk);
    wr = 1'b0; drv_en = 1'b0;
    #1 check_val("rel_rdata_held", data_io, 8'h02);
    @(posedge clk); #1 check_val("rel_wr_rd_stored", data_io, 8'h5a);
    @(negedge clk); rd = 1'b0;

    // Clear
    for (int i = 0; i < 32; i++) begin
      rv = 8'(i);
      do_write(rv[4:0], 8'h00);
    end
    for (int i = 0; i < 32; i++) begin
      logic [7:0] a;
      a = 8'(i);
      do_read(a[4:0], rv);
      check_val($sformatf("clear_%0d", i), rv, 8'h00);
    end

    // Overwrite: last write wins
    do_write(5'h1e, 8'hab);
    do_write(5'h1e, 8'h19);
    do_write(5'h1e, 8'h34);
    do_read(5'h1e, rv);
    check_val("overwrite", rv, 8'h34);

    // Reset overrides a concurrent write
    do_write(5'd4, 8'h77);
    do_read(5'd4, rv);
    check_val("pre_reset_4", rv, 8'h77);
    @(negedge clk);
    rst = 1'b1; wr = 1'b1; rd = 1'b0; addr = 5'd4; drv = 8'h11; drv_en = 1'b1;
    @(negedge clk);
    rst = 1'b0; wr = 1'b0; drv_en = 1'b0; rd = 1'b1;
    #1 check_val("post_reset_rdata", data_io, 8'h00);
    @(posedge clk);
`ifdef MEM_RST_CLEAR_EN
    #1 check_val("post_reset_mem4", data_io, 8'h00);
`else
    #1 check_val("post_reset_mem4", data_io, 8'h77);
`endif
    @(negedge clk); rd = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
